// File: rtl/mem_access_unit.sv
// Memory access unit: serialises single-word loads/stores onto one memory port and rejects
// kernel-mode accesses to the upper half. Define MAU_RMW_EN to enable partial-store read-modify-write.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        operationMode,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [15:0] reqAddress,
    input  logic [31:0] reqData,
    input  logic [3:0]  reqByteEn,
    output logic        respValid,
    output logic [31:0] respData,
    output logic        respFault,
    output logic [15:0] memAccessAddress,
    output logic        memAccessWren,
    output logic [31:0] memAccessData,
    output logic        memAccessRden,
    input  logic [31:0] memAccessOutput
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdWait,
        StMerge,
        StWr,
        StResp
    } state_e;

    state_e state_q;

    logic req_fault;
    logic req_none;
    logic req_full;

    assign req_fault = operationMode & reqAddress[15];
    assign req_none  = (reqByteEn == 4'h0);
    assign req_full  = (reqByteEn == 4'hF);

    // Gated by rst_n so the port reads 0 for the whole reset window, not just after an edge.
    assign reqReady = (state_q == StIdle) & rst_n;

`ifdef MAU_RMW_EN
    logic        write_q;
    logic [15:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic [31:0] merged;

    always_comb begin
        merged = memAccessOutput;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = data_q[8*i +: 8];
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            respValid        <= 1'b0;
            respFault        <= 1'b0;
            respData         <= 32'h0;
            memAccessAddress <= 16'h0;
            memAccessWren    <= 1'b0;
            memAccessData    <= 32'h0;
            memAccessRden    <= 1'b0;
`ifdef MAU_RMW_EN
            write_q          <= 1'b0;
            addr_q           <= 16'h0;
            data_q           <= 32'h0;
            be_q             <= 4'h0;
`endif
        end else begin
            // Strobes and the bus are single-cycle; each state re-asserts only what it owns.
            respValid        <= 1'b0;
            respFault        <= 1'b0;
            memAccessRden    <= 1'b0;
            memAccessWren    <= 1'b0;
            memAccessAddress <= 16'h0;
            memAccessData    <= 32'h0;

            case (state_q)
                StIdle: begin
                    if (reqValid) begin
`ifdef MAU_RMW_EN
                        write_q <= reqWrite;
                        addr_q  <= reqAddress;
                        data_q  <= reqData;
                        be_q    <= reqByteEn;
`endif
                        if (req_fault) begin
                            state_q   <= StResp;
                            respValid <= 1'b1;
                            respFault <= 1'b1;
                        end else if (!reqWrite) begin
                            state_q          <= StRd;
                            memAccessRden    <= 1'b1;
                            memAccessAddress <= reqAddress;
                        end else if (req_none) begin
                            state_q   <= StResp;
                            respValid <= 1'b1;
                        end else if (req_full) begin
                            state_q          <= StWr;
                            memAccessWren    <= 1'b1;
                            memAccessAddress <= reqAddress;
                            memAccessData    <= reqData;
                        end else begin
`ifdef MAU_RMW_EN
                            state_q          <= StRd;
                            memAccessRden    <= 1'b1;
                            memAccessAddress <= reqAddress;
`else
                            state_q   <= StResp;
                            respValid <= 1'b1;
                            respFault <= 1'b1;
`endif
                        end
                    end
                end

                StRd: begin
`ifdef MAU_RMW_EN
                    state_q <= write_q ? StMerge : StRdWait;
`else
                    state_q <= StRdWait;
`endif
                end

                StRdWait: begin
                    respData  <= memAccessOutput;
                    respValid <= 1'b1;
                    state_q   <= StResp;
                end

`ifdef MAU_RMW_EN
                StMerge: begin
                    memAccessWren    <= 1'b1;
                    memAccessAddress <= addr_q;
                    memAccessData    <= merged;
                    state_q          <= StWr;
                end
`endif

                StWr: begin
                    respValid <= 1'b1;
                    state_q   <= StResp;
                end

                StResp: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit with a word-level memory reference model.
// Expectations follow MAU_RMW_EN the same way the design does.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        operationMode = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [15:0] reqAddress = 16'h0;
    logic [31:0] reqData = 32'h0;
    logic [3:0]  reqByteEn = 4'h0;
    logic        respValid;
    logic [31:0] respData;
    logic        respFault;
    logic [15:0] memAccessAddress;
    logic        memAccessWren;
    logic [31:0] memAccessData;
    logic        memAccessRden;
    logic [31:0] memAccessOutput;

    mem_access_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .operationMode    (operationMode),
        .reqValid         (reqValid),
        .reqReady         (reqReady),
        .reqWrite         (reqWrite),
        .reqAddress       (reqAddress),
        .reqData          (reqData),
        .reqByteEn        (reqByteEn),
        .respValid        (respValid),
        .respData         (respData),
        .respFault        (respFault),
        .memAccessAddress (memAccessAddress),
        .memAccessWren    (memAccessWren),
        .memAccessData    (memAccessData),
        .memAccessRden    (memAccessRden),
        .memAccessOutput  (memAccessOutput)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    // Memory attached to the DUT port: read data appears the cycle after the read strobe.
    logic [31:0] mem [0:65535];
    bit          written [0:65535];
    logic [31:0] mem_out = 32'h0;
    assign memAccessOutput = mem_out;

    always @(posedge clk) begin
        if (memAccessRden) begin
            mem_out <= written[memAccessAddress] ? mem[memAccessAddress]
                                                 : init_word(memAccessAddress);
        end
        if (memAccessWren) begin
            mem[memAccessAddress]     <= memAccessData;
            written[memAccessAddress] <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        fault;
        logic        is_load;
        logic [31:0] data;
        int          due;
    } resp_t;

    typedef struct {
        logic        is_write;
        logic [15:0] addr;
        logic [31:0] data;
        int          due;
    } acc_t;

    resp_t       exp_resp[$];
    acc_t        exp_acc[$];
    logic [31:0] ref_mem[int];
    logic [31:0] last_load = 32'h0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one request at a negedge, waits for acceptance, records the expected outcome.
    task automatic issue(input logic mode, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] be, output int waited);
        resp_t r;
        acc_t  x;
        int    n;
        operationMode = mode;
        reqWrite      = wr;
        reqAddress    = a;
        reqData       = d;
        reqByteEn     = be;
        reqValid      = 1'b1;
        #1;
        waited = 0;
        while (!reqReady && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!reqReady) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: reqReady=%0b after %0d cycles, want 1", reqReady, waited);
            reqValid = 1'b0;
            return;
        end
        n = cyc;
        r.fault   = 1'b0;
        r.is_load = 1'b0;
        r.data    = 32'h0;
        r.due     = n + 1;
        if (mode && a[15]) begin
            r.fault = 1'b1;
        end else if (!wr) begin
            r.is_load  = 1'b1;
            r.data     = ref_read(a);
            r.due      = n + 3;
            x.is_write = 1'b0;
            x.addr     = a;
            x.data     = 32'h0;
            x.due      = n + 1;
            exp_acc.push_back(x);
        end else if (be == 4'h0) begin
            r.due = n + 1;
        end else if (be == 4'hF) begin
            x.is_write = 1'b1;
            x.addr     = a;
            x.data     = d;
            x.due      = n + 1;
            exp_acc.push_back(x);
            ref_mem[int'(a)] = d;
            r.due = n + 2;
        end else begin
`ifdef MAU_RMW_EN
            begin
                logic [31:0] word;
                word = ref_read(a);
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) word[8*i +: 8] = d[8*i +: 8];
                end
                x.is_write = 1'b0;
                x.addr     = a;
                x.data     = 32'h0;
                x.due      = n + 1;
                exp_acc.push_back(x);
                x.is_write = 1'b1;
                x.data     = word;
                x.due      = n + 3;
                exp_acc.push_back(x);
                ref_mem[int'(a)] = word;
                r.due = n + 4;
            end
`else
            r.fault = 1'b1;
`endif
        end
        exp_resp.push_back(r);
        @(posedge clk);
        #1;
        // Junk on the request bus while busy must be ignored; the mode stays held.
        reqValid   = 1'($urandom_range(0, 1));
        reqWrite   = 1'($urandom_range(0, 1));
        reqAddress = 16'($urandom);
        reqData    = $urandom;
        reqByteEn  = 4'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        reqValid = 1'b0;
        while ((exp_resp.size() != 0 || exp_acc.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_resp.size() != 0 || exp_acc.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d responses and %0d accesses outstanding, want 0",
                     exp_resp.size(), exp_acc.size());
        end
    endtask

    // Monitor: response and memory-port checks, decoupled from stimulus.
    initial forever begin
        resp_t e;
        acc_t  x;
        @(negedge clk);
        check("rd_wr_exclusive", 64'(memAccessRden & memAccessWren), 64'd0);
        if (!respValid) begin
            check("fault_unqualified", 64'(respFault), 64'd0);
        end else if (exp_resp.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_unexpected: respValid=1 fault=%0b at cycle %0d, want no response",
                     respFault, cyc);
        end else begin
            e = exp_resp.pop_front();
            check("resp_cycle", 64'(cyc), 64'(e.due));
            check("resp_fault", 64'(respFault), 64'(e.fault));
            check("resp_data", 64'(respData), 64'(e.is_load ? e.data : last_load));
            if (e.is_load) last_load = e.data;
        end
        if (memAccessRden || memAccessWren) begin
            if (exp_acc.size() == 0) begin
                total++;
                bad++;
                $display("FAIL acc_unexpected: rden=%0b wren=%0b addr=0x%0h at cycle %0d, want none",
                         memAccessRden, memAccessWren, memAccessAddress, cyc);
            end else begin
                x = exp_acc.pop_front();
                check("acc_kind", 64'(memAccessWren), 64'(x.is_write));
                check("acc_addr", 64'(memAccessAddress), 64'(x.addr));
                check("acc_data", 64'(memAccessData), 64'(x.data));
                check("acc_cycle", 64'(cyc), 64'(x.due));
            end
        end else begin
            check("bus_idle", 64'({memAccessAddress, memAccessData}), 64'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [15:0] a;
        logic [3:0]  be;
        int          r;

        #1 rst_n = 1'b0;
        #1;
        check("rst_reqReady", 64'(reqReady), 64'd0);
        check("rst_respValid", 64'(respValid), 64'd0);
        check("rst_respFault", 64'(respFault), 64'd0);
        check("rst_respData", 64'(respData), 64'd0);
        check("rst_mem_bus", 64'({memAccessRden, memAccessWren, memAccessAddress, memAccessData}),
              64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, w);
        check("accept_first_edge", 64'(w), 64'd0);
        @(negedge clk);
        issue(1'b0, 1'b0, 16'h0010, 32'h0, 4'h0, w);
        @(negedge clk);
        issue(1'b1, 1'b0, 16'h8000, 32'h0, 4'h0, w);
        @(negedge clk);
        issue(1'b0, 1'b0, 16'h8000, 32'h0, 4'h0, w);
        @(negedge clk);
        issue(1'b0, 1'b1, 16'h0011, 32'h12345678, 4'h0, w);
        @(negedge clk);
        issue(1'b0, 1'b1, 16'h0020, 32'h11223344, 4'hF, w);
        @(negedge clk);
        issue(1'b0, 1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, w);
        @(negedge clk);
        issue(1'b0, 1'b0, 16'h0020, 32'h0, 4'h0, w);
        drain();
`ifdef MAU_RMW_EN
        check("mem_word_0020", 64'(mem[16'h0020]), 64'(32'h11BB33DD));
`else
        check("mem_word_0020", 64'(mem[16'h0020]), 64'(32'h11223344));
`endif

        // Reset while a load sits in RD_WAIT.
        @(negedge clk);
        issue(1'b0, 1'b0, 16'h0005, 32'h0, 4'h0, w);
        reqValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_respValid", 64'(respValid), 64'd0);
        check("midrst_respData", 64'(respData), 64'd0);
        check("midrst_reqReady", 64'(reqReady), 64'd0);
        check("midrst_mem_bus", 64'({memAccessRden, memAccessWren, memAccessAddress,
                                      memAccessData}), 64'd0);
        exp_resp.delete();
        exp_acc.delete();
        last_load = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 1'b1, 16'h0006, 32'hCAFEF00D, 4'hF, w);
        check("accept_after_midrst", 64'(w), 64'd0);
        @(negedge clk);
        issue(1'b0, 1'b0, 16'h0006, 32'h0, 4'h0, w);
        drain();

        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            a  = {1'($urandom_range(0, 1)), 11'd0, 4'($urandom_range(0, 15))};
            r  = int'($urandom_range(0, 9));
            be = (r < 3) ? 4'hF : (r < 5) ? 4'h0 : 4'($urandom);
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, be, w);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port operationMode, input, 1 bit: 1 = kernel bank, 0 = user bank; sampled at request acceptance.
REQ-004 SHALL have port reqValid, input, 1 bit: requester has a valid request.
REQ-005 SHALL have port reqReady, output, 1 bit: unit can accept a request.
REQ-006 SHALL have port reqWrite, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port reqAddress, input, 16 bits: word address.
REQ-008 SHALL have port reqData, input, 32 bits: store data.
REQ-009 SHALL have port reqByteEn, input, 4 bits: store byte enables; bit i selects data bits [8i+7:8i]; ignored for loads.
REQ-010 SHALL have port respValid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port respData, output, 32 bits: load data, valid only while respValid=1 for a load.
REQ-012 SHALL have port respFault, output, 1 bit: the completing request was rejected, qualified by respValid.
REQ-013 SHALL have ports memAccessAddress (output, 16 bits), memAccessWren (output, 1 bit), memAccessData (output, 32 bits) and memAccessRden (output, 1 bit): all registered drives to the operational memory access port.
REQ-014 SHALL have port memAccessOutput, input, 32 bits: memory read data, valid the cycle after memAccessRden=1.

Function
REQ-015 SHALL implement FSM states IDLE, RD, RD_WAIT, MERGE, WR and RESP.
REQ-016 SHALL drive reqReady=1 only in IDLE with rst_n high.
REQ-017 SHALL accept a request on a rising edge where reqValid=1 and reqReady=1, latching operationMode, reqWrite, reqAddress, reqData and reqByteEn.
REQ-018 SHALL treat a request as a fault when the latched operationMode=1 and reqAddress[15]=1; fault path: IDLE->RESP, respFault=1, no memory strobe.
REQ-019 SHALL complete a write with reqByteEn=4'h0 as IDLE->RESP, respFault=0, no memory strobe.
REQ-020 SHALL process a load accepted in cycle N as: N+1 RD (memAccessRden=1), N+2 RD_WAIT (capture memAccessOutput into respData), N+3 RESP (respValid=1).
REQ-021 SHALL process a store with reqByteEn=4'hF accepted in cycle N as: N+1 WR (memAccessWren=1, memAccessData=reqData), N+2 RESP.
REQ-022 SHALL process a partial store as: N+1 RD, N+2 MERGE (merged word = enabled bytes from reqData, other bytes from memAccessOutput), N+3 WR with the merged word, N+4 RESP.
REQ-023 SHALL assert memAccessRden and memAccessWren for exactly one cycle per access, never both in the same cycle.
REQ-024 SHALL drive memAccessRden=0, memAccessWren=0, memAccessAddress=0 and memAccessData=0 in every state other than RD or WR.
REQ-025 SHALL hold respData from the last load until the next load completes; respFault SHALL be 0 whenever respValid=0.
REQ-026 SHALL return RESP->IDLE unconditionally, so back-to-back requests are spaced at least one idle-accept cycle apart.
REQ-027 SHALL ignore reqValid outside IDLE; the requester holds operationMode stable from acceptance until respValid.

Reset
REQ-028 SHALL, while rst_n=0 and regardless of clock, force state=IDLE, reqReady=0, respValid=0, respFault=0, respData=0 and all memAccess* outputs to 0.
REQ-029 SHALL abort an in-flight request when reset is asserted mid-transaction: no later memory strobe and no respValid for it.
REQ-030 SHALL allow acceptance on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, with macro MAU_RMW_EN defined, implement the partial-store read-modify-write path of REQ-022.
REQ-032 SHALL, with MAU_RMW_EN undefined, complete a store with reqByteEn not equal to 4'h0 or 4'hF as IDLE->RESP with respFault=1 and no memory access, and omit the MERGE state logic.

Verification
REQ-033 SHALL verify: store addr 0x0010, data 0xDEADBEEF, byteEn F, then load 0x0010 -> memAccessWren pulse at N+1; load respValid at N+3 with respData=0xDEADBEEF.
REQ-034 SHALL verify (MAU_RMW_EN): mem[0x0020]=0x11223344; store data 0xAABBCCDD, byteEn 4'b0101 -> written word 0x11BB33DD, respValid at N+4, respFault=0.
REQ-035 SHALL verify: operationMode=1, load addr 0x8000 -> respValid and respFault at N+1; memAccessRden never asserted.
REQ-036 SHALL verify: rst_n pulled low during RD_WAIT of a load -> outputs 0 immediately; no respValid; next request after release completes normally.
REQ-037 SHALL verify (MAU_RMW_EN undefined): store byteEn 4'b0011 -> respFault=1 at N+1; memory word unchanged.
